sram_rw_arbiter: RTL
====================

# sram_rw_arbiter

Two-port round-robin arbiter and sequencer for the single-RW-port 32x256 OpenRAM SRAM macro. Two requesters (e.g. a Wishbone slave bridge and a logic-analyzer/DMA engine) each present a valid/ready request. The block grants one request at a time and drives the macro's registered csb0/web0/wmask0/addr0/din0 pins. It captures dout0 on the correct edge and returns a one-cycle response pulse to the granted port. It sits between the user-project bus logic and the SRAM macro instance.

## Interface
- ADDR_WIDTH, 8, macro address width (256 words)
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-write mask width (DATA_WIDTH/8)

- wb_clk_i  in  1  clock; also drives macro clk0
- wb_rst_i  in  1  synchronous, active-high reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle (combinational)
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_wmask / p1_req_wmask  in  NUM_WMASKS  byte enables for writes
- p0_req_addr / p1_req_addr  in  ADDR_WIDTH  word address
- p0_req_wdata / p1_req_wdata  in  DATA_WIDTH  write data
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid with the rsp_valid pulse of a read
- busy  out  1  FSM not in IDLE
- sram_csb0  out  1  macro chip select, active low
- sram_web0  out  1  macro write enable, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any req_valid is high, select a winner and assert that port's req_ready combinationally.
  - On the clock edge, register the macro pins: csb0=0; web0=~we; wmask0=we?wmask:0; addr0=addr; din0=we?wdata:0.
  - Register the grant and go to ISSUE.
  - Never assert both req_ready signals in the same cycle.
- ISSUE: macro pins hold the access, and the macro samples them at the next edge. At that edge, drive csb0=1 (other pins hold) and go to WAIT.
- WAIT: the macro completes the write or read at the negedge, and dout0 settles before the following posedge. At the next edge:
  - For a read, capture sram_dout0 into rsp_rdata. For a write, rsp_rdata holds its value.
  - Pulse the granted port's rsp_valid for exactly one cycle.
  - Go to IDLE.
- Round-robin:
  - A last_grant register updates on each accept.
  - With both ports valid, grant the port that was not last granted.
  - With one port valid, grant it regardless of history.
- A requester must hold valid and its payload stable until ready. The block does not buffer unaccepted requests.
- Reset behaviour:
  - wb_rst_i forces IDLE, and the macro pins are registered to csb0=1, web0=1, zeros elsewhere.
  - last_grant is set to 1, so port 0 wins the first tie.
  - Reset in ISSUE: the macro samples the pre-reset pins at the reset edge, so the access (including a write) may complete in the macro. No rsp_valid is issued.
  - Reset in WAIT: the response is dropped.

## Timing
- Accept at edge E; macro samples at E+1; rsp_valid is high during the cycle after edge E+2.
- Latency: 3 cycles from accept to response. Peak throughput is 1 access per 3 cycles, because a new accept may occur in the same IDLE cycle that carries the rsp_valid pulse.
- csb0 is low for exactly one macro sampling edge per access.
- Reset values: all req_ready=0 while wb_rst_i=1, all rsp_valid=0, rsp_rdata=0, busy=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
- A write with wmask=0 is issued normally (macro no-op) and is acknowledged.
- Address wrap: none. The full 8-bit address passes through.

## Test plan
- Reset, then port 0 writes addr 0x10, data 0xDEADBEEF, wmask 0xF. Then port 0 reads addr 0x10 -> rsp_rdata=0xDEADBEEF with p0_rsp_valid, 3 cycles after the accept. Check p1_rsp_valid=0 throughout.
- Byte-mask write: write 0x11223344 to addr 0x20, then write 0xAABBCCDD with wmask 0x5 -> a read returns 0x11BB33DD.
- Both ports hold valid continuously with distinct addresses -> grants alternate p0, p1, p0, p1. Each response goes only to its owner. An accept occurs every 3 cycles.
- Port 1 alone is valid after a p1 grant -> p1 is granted again with no idle gap. Then both valid -> p0 wins.
- Assert wb_rst_i during ISSUE of a read -> no rsp_valid. On the next edge csb0=1 and busy=0, and a subsequent read completes normally.
- Protocol check across all scenarios: sram_csb0 is low for exactly 1 cycle per accepted request, and req_ready is never high for both ports at once.

Source files
------------

// File: rtl/sram_rw_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a single
// RW-port 32x256 SRAM macro with registered macro pins.
module sram_rw_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [NUM_WMASKS-1:0] p0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [NUM_WMASKS-1:0] p1_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,

    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic                    csb_q, csb_d;
    logic                    web_q, web_d;
    logic [NUM_WMASKS-1:0]   wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rsp0_q, rsp0_d;
    logic                    rsp1_q, rsp1_d;

    logic                    sel1;
    logic                    sel0;
    logic                    accept;
    logic                    req_we;
    logic [NUM_WMASKS-1:0]   req_wmask;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // Pick a winner: port 1 only when port 0 is absent or port 0 went last.
    always_comb begin
        sel1   = p1_req_valid & (~p0_req_valid | ~last_grant_q);
        sel0   = p0_req_valid & ~sel1;
        accept = (state_q == IDLE) & ~wb_rst_i
               & (p0_req_valid | p1_req_valid);
        if (sel1) begin
            req_we    = p1_req_we;
            req_wmask = p1_req_wmask;
            req_addr  = p1_req_addr;
            req_wdata = p1_req_wdata;
        end else begin
            req_we    = p0_req_we;
            req_wmask = p0_req_wmask;
            req_addr  = p0_req_addr;
            req_wdata = p0_req_wdata;
        end
    end

    assign p0_req_ready = accept & sel0;
    assign p1_req_ready = accept & sel1;

    // Next-state and next macro-pin values for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        csb_d        = csb_q;
        web_d        = web_q;
        wmask_d      = wmask_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rdata_d      = rdata_q;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE;
                    grant_d      = sel1;
                    last_grant_d = sel1;
                    csb_d        = 1'b0;
                    web_d        = ~req_we;
                    wmask_d      = req_we ? req_wmask : '0;
                    addr_d       = req_addr;
                    din_d        = req_we ? req_wdata : '0;
                end
            end
            ISSUE: begin
                csb_d   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (web_q) begin
                    rdata_d = sram_dout0;
                end
                rsp0_d  = ~grant_q;
                rsp1_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant history, macro pins and response registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            wmask_q      <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            rdata_q      <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            wmask_q      <= wmask_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rdata_q      <= rdata_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
        end
    end

    assign p0_rsp_valid = rsp0_q;
    assign p1_rsp_valid = rsp1_q;
    assign rsp_rdata    = rdata_q;
    assign busy         = (state_q != IDLE);
    assign sram_csb0    = csb_q;
    assign sram_web0    = web_q;
    assign sram_wmask0  = wmask_q;
    assign sram_addr0   = addr_q;
    assign sram_din0    = din_q;

endmodule
